// File: rtl/arith_enc_pkg.sv
// Shared constants, FSM state type and mask helper for the arithmetic-encoder
// renormalisation controller.
package arith_enc_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned ACC_W  = 2 * WORD_W;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned FILL_W = $clog2(ACC_W + 1);

   localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
   localparam logic [FILL_W-1:0] ROOM_FILL = FILL_W'(ACC_W - WORD_W);
   localparam logic [CNT_W-1:0]  WORD_CNT  = CNT_W'(WORD_W);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, FLUSH} seq_state_t;

   // Left-justified mask with `count` ones; counts above WORD_W saturate.
   function automatic logic [WORD_W-1:0] count_to_mask(input logic [CNT_W-1:0] count);
      logic [WORD_W-1:0] ones;
      ones = '1;
      if (count >= WORD_CNT) return ones;
      return ~(ones >> count);
   endfunction

endpackage

// File: rtl/bit_packer.sv
// MSB-first bit accumulator: appends variable-length bit groups and emits
// fixed-width words over a valid/ready handshake, with end-of-stream flush.
module bit_packer
   import arith_enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              app_en,
   input  logic [WORD_W-1:0] app_data,
   input  logic [CNT_W-1:0]  app_count,
   input  logic              flush,
   output logic [FILL_W-1:0] fill,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last
);

   logic [ACC_W-1:0]  acc_q, acc_d, acc_shift;
   logic [FILL_W-1:0] fill_q, fill_d, fill_shift;
   logic              emit;

   assign fill    = fill_q;
   assign m_data  = acc_q[ACC_W-1 -: WORD_W];
   // In flush there is always a word to send, even an all-zero one.
   assign m_valid = (fill_q >= WORD_FILL) | flush;
   assign m_last  = flush & (fill_q <= WORD_FILL);
   assign emit    = m_valid & m_ready;

   // Emit shifts first; a same-cycle append lands at the post-shift fill.
   always_comb begin
      acc_shift  = acc_q;
      fill_shift = fill_q;
      if (emit) begin
         acc_shift  = acc_q << WORD_W;
         fill_shift = (fill_q >= WORD_FILL) ? (fill_q - WORD_FILL) : '0;
      end
      acc_d  = acc_shift;
      fill_d = fill_shift;
      if (app_en) begin
         acc_d  = acc_shift | ({app_data, {WORD_W{1'b0}}} >> fill_shift);
         fill_d = fill_shift + FILL_W'(app_count);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         fill_q <= '0;
      end else begin
         acc_q  <= acc_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/out_bits_sequencer.sv
// Sequencer around the out_bits renormalisation stage: issue bounds, capture results,
// pack emitted bits. Define OUT_BITS_SEQ_STATS_EN to add the stat_* counter ports.
module out_bits_sequencer
   import arith_enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_upper,
   input  logic [WORD_W-1:0] s_lower,
   input  logic              s_last,
   output logic [WORD_W-1:0] ob_upper,
   output logic [WORD_W-1:0] ob_lower,
   input  logic [WORD_W-1:0] ob_new_upper,
   input  logic [WORD_W-1:0] ob_new_lower,
   input  logic [WORD_W-1:0] ob_bits,
   input  logic [WORD_W-1:0] ob_mask,
   input  logic [CNT_W-1:0]  ob_count,
   output logic              r_valid,
   output logic [WORD_W-1:0] r_upper,
   output logic [WORD_W-1:0] r_lower,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last
`ifdef OUT_BITS_SEQ_STATS_EN
   ,
   output logic [31:0]       stat_bits,
   output logic [31:0]       stat_stall,
   output logic              stat_mask_err
`endif
);

   seq_state_t        state_q, state_d;
   logic              last_q;
   logic              accept, capture, flush, m_take;
   logic [CNT_W-1:0]  cnt_sat;
   logic [FILL_W-1:0] fill;

   assign cnt_sat = (ob_count > WORD_CNT) ? WORD_CNT : ob_count;
   assign capture = (state_q == CAPTURE);
   assign flush   = (state_q == FLUSH);
   // Gated by rst so the request side stays closed while reset is held.
   assign s_ready = rst & (state_q == IDLE) & (fill <= ROOM_FILL);
   assign accept  = s_valid & s_ready;
   assign m_take  = m_valid & m_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = last_q ? FLUSH : IDLE;
         FLUSH:   if (m_take && m_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b0;
         ob_upper <= '0;
         ob_lower <= '0;
         r_valid  <= 1'b0;
         r_upper  <= '0;
         r_lower  <= '0;
      end else begin
         state_q <= state_d;
         r_valid <= capture;
         if (accept) begin
            ob_upper <= s_upper;
            ob_lower <= s_lower;
            last_q   <= s_last;
         end
         if (capture) begin
            r_upper <= ob_new_upper;
            r_lower <= ob_new_lower;
         end
      end
   end

   bit_packer u_bit_packer (
      .clk       (clk),
      .rst       (rst),
      .app_en    (capture),
      .app_data  (ob_bits & ob_mask),
      .app_count (cnt_sat),
      .flush     (flush),
      .fill      (fill),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

`ifdef OUT_BITS_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_bits     <= '0;
         stat_stall    <= '0;
         stat_mask_err <= 1'b0;
      end else begin
         if (capture) begin
            stat_bits <= stat_bits + 32'(cnt_sat);
            if (ob_mask != count_to_mask(cnt_sat)) stat_mask_err <= 1'b1;
         end
         if (m_valid && !m_ready) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_out_bits_sequencer.sv
// Bench for out_bits_sequencer: bit-queue model of the packer, stub out_bits stage,
// and directed scenarios with literal word expectations.
module tb_out_bits_sequencer;
   import arith_enc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_upper = '0;
   logic [15:0] s_lower = '0;
   logic        s_last = 1'b0;
   logic [15:0] ob_upper, ob_lower;
   logic [15:0] ob_new_upper = '0;
   logic [15:0] ob_new_lower = '0;
   logic [15:0] ob_bits = '0;
   logic [15:0] ob_mask = '0;
   logic [4:0]  ob_count = '0;
   logic        r_valid;
   logic [15:0] r_upper, r_lower;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [15:0] m_data;
   logic        m_last;
`ifdef OUT_BITS_SEQ_STATS_EN
   logic [31:0] stat_bits, stat_stall;
   logic        stat_mask_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   bit          bitq[$];
   logic [15:0] exp_d[$];
   bit          exp_l[$];
   logic [15:0] exp_ru[$];
   logic [15:0] exp_rl[$];
   logic [15:0] log_d[$];
   bit          log_l[$];

   out_bits_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_upper      (s_upper),
      .s_lower      (s_lower),
      .s_last       (s_last),
      .ob_upper     (ob_upper),
      .ob_lower     (ob_lower),
      .ob_new_upper (ob_new_upper),
      .ob_new_lower (ob_new_lower),
      .ob_bits      (ob_bits),
      .ob_mask      (ob_mask),
      .ob_count     (ob_count),
      .r_valid      (r_valid),
      .r_upper      (r_upper),
      .r_lower      (r_lower),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last)
`ifdef OUT_BITS_SEQ_STATS_EN
      ,
      .stat_bits     (stat_bits),
      .stat_stall    (stat_stall),
      .stat_mask_err (stat_mask_err)
`endif
   );

   always #5 clk = ~clk;

   // Stub out_bits stage: one registered cycle, easily predicted bound transform.
   always @(posedge clk) begin
      ob_new_upper <= {ob_upper[14:0], 1'b1};
      ob_new_lower <= {ob_lower[14:0], 1'b0};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lj_mask(input int c);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < c && i < 16; i++) m = {1'b1, m[15:1]};
      return m;
   endfunction

   task automatic pop_word(input bit last);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         if (bitq.size() > 0) w = {w[14:0], bitq.pop_front()};
         else                 w = {w[14:0], 1'b0};
      end
      exp_d.push_back(w);
      exp_l.push_back(last);
   endtask

   // Model: a plain bit stream cut into 16-bit words; last flushes the remainder.
   task automatic model_push(input logic [15:0] bits, input logic [15:0] mask, input int cnt,
                             input bit last);
      logic [15:0] v;
      int c;
      c = (cnt > 16) ? 16 : cnt;
      v = bits & mask;
      for (int i = 0; i < c; i++) begin
         bitq.push_back(v[15]);
         v = v << 1;
      end
      if (last) begin
         while (bitq.size() > 16) pop_word(1'b0);
         pop_word(1'b1);
      end else begin
         while (bitq.size() >= 16) pop_word(1'b0);
      end
   endtask

   task automatic send(input logic [15:0] u, input logic [15:0] l, input logic [15:0] bits,
                       input logic [15:0] mask, input int cnt, input bit last,
                       input bit chk_lat);
      int k;
      @(negedge clk);
      s_valid  = 1'b1;
      s_upper  = u;
      s_lower  = l;
      s_last   = last;
      ob_bits  = bits;
      ob_mask  = mask;
      ob_count = 5'(cnt);
      k = 0;
      while (!s_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!s_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got s_ready=0, expected 1 within 100 cycles");
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_push(bits, mask, cnt, last);
      exp_ru.push_back({u[14:0], 1'b1});
      exp_rl.push_back({l[14:0], 1'b0});
      #1 s_valid = 1'b0;
      // Hold ob_* stable until the capture edge has passed.
      @(negedge clk);
      if (chk_lat) check("lat_issue", 32'(r_valid), 32'd0);
      @(negedge clk);
      if (chk_lat) check("lat_capture", 32'(r_valid), 32'd0);
      @(negedge clk);
      if (chk_lat) check("lat_rvalid", 32'(r_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_d.size() != 0 || m_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(exp_d.size()), 32'd0);
   endtask

   // Compare process: runs just after each falling edge, after inputs settle.
   initial begin
      bit          prev_stall;
      logic [15:0] prev_d;
      logic        prev_l;
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_l     = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(m_valid), 32'd1);
               check("hold_data", 32'(m_data), 32'(prev_d));
               check("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && m_ready) begin
               if (exp_d.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got %h, expected no word", m_data);
               end else begin
                  check("word_data", 32'(m_data), 32'(exp_d.pop_front()));
                  check("word_last", 32'(m_last), 32'(exp_l.pop_front()));
               end
               log_d.push_back(m_data);
               log_l.push_back(m_last);
            end
            if (r_valid) begin
               if (exp_ru.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_r: got %h, expected no r_valid", r_upper);
               end else begin
                  check("r_upper", 32'(r_upper), 32'(exp_ru.pop_front()));
                  check("r_lower", 32'(r_lower), 32'(exp_rl.pop_front()));
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int base;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_r_valid", 32'(r_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_ob_upper", 32'(ob_upper), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 32'd1);

      // Single request with last.
      base = log_d.size();
      send(16'h8001, 16'h0100, 16'h4000, lj_mask(2), 2, 1'b1, 1'b1);
      drain("t1_drain");
      check("t1_n", 32'(log_d.size() - base), 32'd1);
      check("t1_word", 32'(log_d[base]), 32'h4000);
      check("t1_last", 32'(log_l[base]), 32'd1);

      // Eight 2-bit groups make one full word.
      base = log_d.size();
      for (int i = 0; i < 8; i++)
         send(16'(16'h1000 + i), 16'(i), 16'h4000, lj_mask(2), 2, 1'b0, 1'b0);
      drain("t2_drain");
      check("t2_n", 32'(log_d.size() - base), 32'd1);
      check("t2_word", 32'(log_d[base]), 32'h5555);
      check("t2_last", 32'(log_l[base]), 32'd0);

      // Backpressure: accumulator full blocks requests.
      base = log_d.size();
      @(negedge clk);
      m_ready = 1'b0;
      send(16'hFFFF, 16'h0000, 16'hFFFF, lj_mask(16), 16, 1'b0, 1'b0);
      send(16'h7000, 16'h0700, 16'h0000, lj_mask(16), 16, 1'b0, 1'b0);
      check("t3_full_s_ready", 32'(s_ready), 32'd0);
      check("t3_full_m_valid", 32'(m_valid), 32'd1);
      check("t3_full_m_data", 32'(m_data), 32'hFFFF);
      repeat (3) @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      check("t3_room_s_ready", 32'(s_ready), 32'd1);
      drain("t3_drain");
      check("t3_n", 32'(log_d.size() - base), 32'd2);
      check("t3_word0", 32'(log_d[base]), 32'hFFFF);
      check("t3_word1", 32'(log_d[base+1]), 32'h0000);

      // Zero-count requests, then flush from empty.
      base = log_d.size();
      for (int i = 0; i < 3; i++)
         send(16'h0F0F, 16'h00F0, 16'hFFFF, lj_mask(0), 0, 1'b0, 1'b0);
      check("t4_nowords", 32'(log_d.size() - base), 32'd0);
      send(16'h0F0F, 16'h00F0, 16'h0000, lj_mask(0), 0, 1'b1, 1'b0);
      drain("t4_drain");
      check("t4_n", 32'(log_d.size() - base), 32'd1);
      check("t4_word", 32'(log_d[base]), 32'h0000);
      check("t4_last", 32'(log_l[base]), 32'd1);

      // Word straddling two groups.
      base = log_d.size();
      send(16'h1234, 16'h0034, 16'hA000, lj_mask(3), 3, 1'b0, 1'b0);
      send(16'h4321, 16'h0021, 16'hFFFE, lj_mask(15), 15, 1'b1, 1'b0);
      drain("t5_drain");
      check("t5_n", 32'(log_d.size() - base), 32'd2);
      check("t5_word0", 32'(log_d[base]), 32'hBFFF);
      check("t5_last0", 32'(log_l[base]), 32'd0);
      check("t5_word1", 32'(log_d[base+1]), 32'hC000);
      check("t5_last1", 32'(log_l[base+1]), 32'd1);

      // Reset during flush with 20 bits buffered.
      @(negedge clk);
      m_ready = 1'b0;
      send(16'hAAAA, 16'h5555, 16'hFFFF, lj_mask(16), 16, 1'b0, 1'b0);
      send(16'hBBBB, 16'h4444, 16'hF000, lj_mask(4), 4, 1'b1, 1'b0);
      check("t6_pre_m_valid", 32'(m_valid), 32'd1);
      check("t6_pre_m_data", 32'(m_data), 32'hFFFF);
      rst = 1'b0;
      bitq.delete();
      exp_d.delete();
      exp_l.delete();
      exp_ru.delete();
      exp_rl.delete();
      #1;
      check("t6_rst_m_valid", 32'(m_valid), 32'd0);
      check("t6_rst_m_data", 32'(m_data), 32'd0);
      check("t6_rst_m_last", 32'(m_last), 32'd0);
      check("t6_rst_r_valid", 32'(r_valid), 32'd0);
      check("t6_rst_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6_quiet_m_valid", 32'(m_valid), 32'd0);
      end
      base = log_d.size();
      send(16'h0001, 16'h0000, 16'hF000, lj_mask(4), 4, 1'b1, 1'b0);
      drain("t6_drain");
      check("t6_n", 32'(log_d.size() - base), 32'd1);
      check("t6_word", 32'(log_d[base]), 32'hF000);

      // Illegal count saturates to a full word.
      base = log_d.size();
      send(16'h0002, 16'h0001, 16'hFFFF, 16'hFFFF, 20, 1'b1, 1'b0);
      drain("t7_drain");
      check("t7_n", 32'(log_d.size() - base), 32'd1);
      check("t7_word", 32'(log_d[base]), 32'hFFFF);
      check("t7_last", 32'(log_l[base]), 32'd1);

      repeat (4) @(negedge clk);
      check("end_words_left", 32'(exp_d.size()), 32'd0);
      check("end_r_left", 32'(exp_ru.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/out_bits_sequencer.md
Name: out_bits_sequencer

Overview:
- Controller for the arithmetic-encoder renormalisation stage `out_bits`.
- Accepts one (upper, lower) bound pair per request and drives it into `out_bits`.
- Captures the stage's shifted-out bits and returns the renormalised bounds to the probability model.
- Packs the variable-count emitted bits MSB-first into fixed-width output words, with valid/ready backpressure and an end-of-stream flush.

Parameters:
- WORD_W, 16, width of bounds, of `out_bits` data and of output words.
- ACC_W, 2*WORD_W, bit-accumulator width.
- CNT_W, 5, width of `out_bits` count (0..WORD_W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid and s_ready are both high
- s_upper  in  WORD_W  upper bound
- s_lower  in  WORD_W  lower bound
- s_last  in  1  final symbol of the stream; triggers flush
- ob_upper  out  WORD_W  bound driven to `out_bits` data_upper_in
- ob_lower  out  WORD_W  bound driven to `out_bits` data_lower_in
- ob_new_upper  in  WORD_W  from `out_bits` data_upper_out
- ob_new_lower  in  WORD_W  from `out_bits` data_lower_out
- ob_bits  in  WORD_W  emitted bits, left-justified
- ob_mask  in  WORD_W  valid-bit mask
- ob_count  in  CNT_W  number of emitted bits
- r_valid  out  1  one-cycle pulse: renormalised bounds valid
- r_upper  out  WORD_W  renormalised upper bound
- r_lower  out  WORD_W  renormalised lower bound
- m_valid  out  1  output word valid
- m_ready  in  1  downstream ready
- m_data  out  WORD_W  packed bits, MSB = oldest bit
- m_last  out  1  final word of the stream

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; fill=0; accumulator=0.
  - s_ready=0 while rst is asserted, then 1 in IDLE.
  - ob_upper, ob_lower, r_upper, r_lower, m_data = 0.
  - r_valid, m_valid, m_last = 0.
  - Reset mid-stream discards all buffered bits and any in-flight request.
- `out_bits` has 1-cycle registered latency; at most one request is in flight. Throughput is one request per 3 cycles.
- FSM:
  - IDLE: s_ready = (fill <= ACC_W-WORD_W) and no flush pending. On accept, register s_upper/s_lower onto ob_upper/ob_lower, latch s_last, go to ISSUE.
  - ISSUE: go to CAPTURE. `out_bits` registers its inputs on this edge.
  - CAPTURE:
    - Sample ob_*.
    - r_upper/r_lower <= ob_new_upper/ob_new_lower; r_valid pulses for 1 cycle.
    - Append (ob_bits & ob_mask) at bit position ACC_W-1-fill.
    - fill += ob_count.
    - If the latched last is set, go to FLUSH; otherwise go to IDLE.
  - FLUSH: drain every full word, then the remaining partial word with zero padding in the LSBs. The final word carries m_last=1. If fill==0 on entry, emit a single 16'h0000 word with m_last=1. Return to IDLE when that word is taken.
- Output side (independent of FSM state):
  - m_valid = (fill >= WORD_W), or FLUSH with words remaining.
  - m_data = accumulator[ACC_W-1 -: WORD_W].
  - On m_valid and m_ready, shift the accumulator left by WORD_W and decrement fill by min(fill, WORD_W).
  - m_valid/m_data/m_last hold stable while m_ready=0.
- Emit and append in the same CAPTURE cycle:
  - Shift first, then append at the post-shift position.
  - fill_next = fill - 16*emit + count.
- Bounds:
  - fill never exceeds ACC_W; this is guaranteed by the s_ready rule.
  - ob_count > WORD_W is illegal; it is saturated to WORD_W.
  - ob_count = 0 still produces r_valid and leaves fill unchanged.

Optional Feature:
- Macro: OUT_BITS_SEQ_STATS_EN.
- When defined:
  - Adds output port stat_bits (32 bits): total bits appended, wraps modulo 2^32.
  - Adds output port stat_stall (32 bits): cycles with m_valid=1 and m_ready=0.
  - Adds output port stat_mask_err (1 bit): sticky flag, set when ob_mask != left-justified mask of ob_count.
  - All three clear on reset.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package arith_enc_pkg holds:
  - WORD_W, ACC_W, CNT_W constants.
  - seq_state_t enum {IDLE, ISSUE, CAPTURE, FLUSH}.
  - Function count_to_mask(count).
- One natural sub-module, `bit_packer`: accumulator, fill counter, shift/append logic and the m_* handshake. The FSM and the bound-return path stay in the top level.

Test Plan:
- Single request, stub count=2, bits=0x4000, s_last=1 -> r_valid pulses 2 cycles after accept; one word m_data=0x4000 with m_last=1.
- Eight requests, each count=2, bits=0x4000 -> one word 0x5555 after the 8th CAPTURE; fill=0; no m_last.
- m_ready held 0; two requests of count=16 with bits 0xFFFF then 0x0000 -> s_ready low after the 2nd capture (fill=32). Releasing m_ready yields 0xFFFF then 0x0000; s_ready returns high after the first word is taken.
- Requests with count=0, then s_last with fill=0 -> no data words, then a single 0x0000 word with m_last=1.
- count=3 bits=0xA000, then count=15 bits=0xFFFE with last -> words 0xBFFF, then 0xC000 with m_last=1.
- rst pulsed low during FLUSH with fill=20 -> outputs cleared immediately; no further m_valid until a new request is captured.
